// File: rtl/jpc_fetch_ctrl.sv
// jpc_fetch_ctrl: fetch sequencer between jpc_pc, the imem port and decode.
// Issues one imem request at a time, buffers one instruction for decode and
// applies branch/jump redirects, killing any fetch still in flight.
// Optional feature macro: JPC_FETCH_MISALIGN_EN (misaligned-redirect fault,
// adds the fault_O port and the FAULT state).
module jpc_fetch_ctrl #(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_I,
  output logic [31:0] next_pc_O,
  output logic        pc_enable_O,
  output logic        imem_req_O,
  output logic [31:0] imem_addr_O,
  input  logic        imem_gnt_I,
  input  logic        imem_rvalid_I,
  input  logic [31:0] imem_rdata_I,
  input  logic        redirect_I,
  input  logic [31:0] redirect_pc_I,
  input  logic        stall_I,
`ifdef JPC_FETCH_MISALIGN_EN
  output logic        fault_O,
`endif
  output logic        instr_valid_O,
  output logic [31:0] instr_O,
  output logic [31:0] instr_pc_O
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
`ifdef JPC_FETCH_MISALIGN_EN
  localparam logic [1:0] FAULT = 2'd3;
`endif

  logic [1:0] state;
  logic       kill;     // the outstanding response belongs to a squashed fetch
  logic       blocked;
  logic       consume;
  logic       redir;
  logic       misal;
  logic       granted;
  logic       accept;

  assign blocked = instr_valid_O & stall_I;
  assign consume = instr_valid_O & ~stall_I;
  // redirects are only meaningful once the sequencer has left IDLE
  assign redir   = redirect_I & (state != IDLE);
`ifdef JPC_FETCH_MISALIGN_EN
  assign misal   = redir & (redirect_pc_I[1:0] != 2'b00);
`else
  assign misal   = 1'b0;
`endif

  assign imem_req_O  = (state == FETCH) & ~blocked;
  assign imem_addr_O = imem_req_O ? pc_I : 32'd0;
  assign granted     = imem_req_O & imem_gnt_I;
  // a response lands in the buffer only when it is live and not overridden
  assign accept      = (state == WAIT) & imem_rvalid_I & ~kill & ~redir;

  // PC update: redirect wins, otherwise step past an accepted instruction
  always_comb begin
    pc_enable_O = 1'b0;
    next_pc_O   = pc_I;
    if (redir && !misal) begin
      pc_enable_O = 1'b1;
      next_pc_O   = redirect_pc_I;
    end else if (accept) begin
      pc_enable_O = 1'b1;
      next_pc_O   = pc_I + PC_STEP;
    end
  end

  // fetch FSM and kill tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      kill  <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (redir) begin
            kill <= granted;
`ifdef JPC_FETCH_MISALIGN_EN
            if (misal) state <= FAULT;
            else
`endif
            state <= granted ? WAIT : FETCH;
          end else if (granted) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redir) begin
            // a coincident response is simply dropped; otherwise kill the next one
            kill <= ~imem_rvalid_I;
`ifdef JPC_FETCH_MISALIGN_EN
            if (misal) state <= FAULT;
            else
`endif
            state <= imem_rvalid_I ? FETCH : WAIT;
          end else if (imem_rvalid_I) begin
            kill  <= 1'b0;
            state <= FETCH;
          end
        end
`ifdef JPC_FETCH_MISALIGN_EN
        FAULT: begin
          if (redir) begin
            // leave via WAIT if a killed response is still owed, keeping one outstanding
            kill <= kill & ~imem_rvalid_I;
            if (misal)                       state <= FAULT;
            else if (kill && !imem_rvalid_I) state <= WAIT;
            else                             state <= FETCH;
          end else if (imem_rvalid_I) begin
            kill <= 1'b0;
          end
        end
`endif
        default: begin
          state <= IDLE;
          kill  <= 1'b0;
        end
      endcase
    end
  end

  // single-entry instruction buffer for decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid_O <= 1'b0;
      instr_O       <= 32'd0;
      instr_pc_O    <= 32'd0;
    end else if (redir) begin
      instr_valid_O <= 1'b0;
    end else if (accept) begin
      instr_valid_O <= 1'b1;
      instr_O       <= imem_rdata_I;
      instr_pc_O    <= pc_I;
    end else if (consume) begin
      instr_valid_O <= 1'b0;
    end
  end

`ifdef JPC_FETCH_MISALIGN_EN
  // one-cycle fault pulse after a misaligned redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_O <= 1'b0;
    else        fault_O <= misal;
  end
`endif

endmodule

// File: tb/tb_jpc_fetch_ctrl.sv
// Self-checking bench for jpc_fetch_ctrl: per-cycle vector tables plus an
// instruction scoreboard fed when a response is driven and drained on consume.
module tb_jpc_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic [31:0] next_pc_O;
  logic        pc_enable_O;
  logic        imem_req_O;
  logic [31:0] imem_addr_O;
  logic        imem_gnt_I = 1'b0;
  logic        imem_rvalid_I = 1'b0;
  logic [31:0] imem_rdata_I = 32'd0;
  logic        redirect_I = 1'b0;
  logic [31:0] redirect_pc_I = 32'd0;
  logic        stall_I = 1'b0;
  logic        instr_valid_O;
  logic [31:0] instr_O;
  logic [31:0] instr_pc_O;
`ifdef JPC_FETCH_MISALIGN_EN
  logic        fault_O;
`endif

  always #5 clk = ~clk;

  jpc_fetch_ctrl #(.PC_STEP(32'd4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_I(pc),
    .next_pc_O(next_pc_O), .pc_enable_O(pc_enable_O),
    .imem_req_O(imem_req_O), .imem_addr_O(imem_addr_O), .imem_gnt_I(imem_gnt_I),
    .imem_rvalid_I(imem_rvalid_I), .imem_rdata_I(imem_rdata_I),
    .redirect_I(redirect_I), .redirect_pc_I(redirect_pc_I), .stall_I(stall_I),
`ifdef JPC_FETCH_MISALIGN_EN
    .fault_O(fault_O),
`endif
    .instr_valid_O(instr_valid_O), .instr_O(instr_O), .instr_pc_O(instr_pc_O)
  );

  // jpc_pc register model
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           pc <= 32'd0;
    else if (pc_enable_O) pc <= next_pc_O;
  end

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        st, gnt, rv;
    logic [31:0] rdat;
    logic        push;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_pcen;
    logic [31:0] e_npc;
    logic        e_ivld;
    logic [31:0] e_ipc, e_instr;
    logic        e_fault;
  } vec_t;

  typedef struct {
    logic [31:0] pc, instr;
  } sb_t;

  vec_t tab[$];
  sb_t  sbq[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] X = 32'hEEEE_EEEE;
  localparam logic [31:0] B = 32'hBAD0_0BAD;

  function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic st,
                              input logic gnt, input logic rv, input logic [31:0] rdat,
                              input logic push, input logic e_req, input logic [31:0] e_addr,
                              input logic e_pcen, input logic [31:0] e_npc, input logic e_ivld,
                              input logic [31:0] e_ipc, input logic [31:0] e_instr,
                              input logic e_fault);
    vec_t v;
    v.rd = rd; v.rpc = rpc; v.st = st; v.gnt = gnt; v.rv = rv; v.rdat = rdat;
    v.push = push; v.e_req = e_req; v.e_addr = e_addr; v.e_pcen = e_pcen;
    v.e_npc = e_npc; v.e_ivld = e_ivld; v.e_ipc = e_ipc; v.e_instr = e_instr;
    v.e_fault = e_fault;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run(input string tag, input vec_t v);
    sb_t e;
    @(negedge clk);
    redirect_I = v.rd; redirect_pc_I = v.rpc; stall_I = v.st;
    imem_gnt_I = v.gnt; imem_rvalid_I = v.rv; imem_rdata_I = v.rdat;
    if (v.push) begin
      e.pc = v.e_npc - 32'd4; e.instr = v.rdat;
      sbq.push_back(e);
    end
    #1;
    chk({tag, ".req"},  imem_req_O,    v.e_req);
    chk({tag, ".addr"}, imem_addr_O,   v.e_addr);
    chk({tag, ".pcen"}, pc_enable_O,   v.e_pcen);
    chk({tag, ".npc"},  next_pc_O,     v.e_npc);
    chk({tag, ".ivld"}, instr_valid_O, v.e_ivld);
    if (v.e_ivld) begin
      chk({tag, ".ipc"},   instr_pc_O, v.e_ipc);
      chk({tag, ".instr"}, instr_O,    v.e_instr);
    end
`ifdef JPC_FETCH_MISALIGN_EN
    chk({tag, ".fault"}, fault_O, v.e_fault);
`endif
    if (instr_valid_O && !stall_I) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s.sb_extra actual pc=%h instr=%h required none", tag, instr_pc_O, instr_O);
      end else begin
        e = sbq.pop_front();
        chk({tag, ".sb_pc"},    instr_pc_O, e.pc);
        chk({tag, ".sb_instr"}, instr_O,    e.instr);
      end
    end
  endtask

  task automatic run_tab(input string tag);
    for (int i = 0; i < tab.size(); i++) run($sformatf("%s%0d", tag, i), tab[i]);
    tab.delete();
  endtask

  // async reset applied away from the clock edge with a stray response driven
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0; redirect_I = 1'b0; stall_I = 1'b0;
    imem_gnt_I = 1'b1; imem_rvalid_I = 1'b1; imem_rdata_I = B;
    #1;
    chk({tag, ".rst_req"},   imem_req_O,    1'b0);
    chk({tag, ".rst_addr"},  imem_addr_O,   32'd0);
    chk({tag, ".rst_pcen"},  pc_enable_O,   1'b0);
    chk({tag, ".rst_npc"},   next_pc_O,     32'd0);
    chk({tag, ".rst_ivld"},  instr_valid_O, 1'b0);
    chk({tag, ".rst_instr"}, instr_O,       32'd0);
    chk({tag, ".rst_ipc"},   instr_pc_O,    32'd0);
`ifdef JPC_FETCH_MISALIGN_EN
    chk({tag, ".rst_fault"}, fault_O,       1'b0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({tag, ".idle_pcen"}, pc_enable_O, 1'b0);
    chk({tag, ".idle_req"},  imem_req_O,  1'b0);
    sbq.delete();
  endtask

  initial begin
    do_reset("r0");
    // back-to-back stream, gnt/rvalid tied high
    tab.push_back(mk(0,0,0,1,1,X,0,           1,32'h0, 0,32'h0,  0,0,0,0));
    tab.push_back(mk(0,0,0,1,1,32'hD0000000,1, 0,32'h0, 1,32'h4,  0,0,0,0));
    tab.push_back(mk(0,0,0,1,1,X,0,           1,32'h4, 0,32'h4,  1,32'h0,32'hD0000000,0));
    tab.push_back(mk(0,0,0,1,1,32'hD0000001,1, 0,32'h0, 1,32'h8,  0,0,0,0));
    tab.push_back(mk(0,0,0,1,1,X,0,           1,32'h8, 0,32'h8,  1,32'h4,32'hD0000001,0));
    tab.push_back(mk(0,0,0,1,1,32'hD0000002,1, 0,32'h0, 1,32'hC,  0,0,0,0));
    tab.push_back(mk(0,0,0,1,1,X,0,           1,32'hC, 0,32'hC,  1,32'h8,32'hD0000002,0));
    tab.push_back(mk(0,0,0,1,1,32'hD0000003,1, 0,32'h0, 1,32'h10, 0,0,0,0));
    tab.push_back(mk(0,0,0,1,1,X,0,           1,32'h10,0,32'h10, 1,32'hC,32'hD0000003,0));
    run_tab("s");

    do_reset("r1");
    // delayed grant, stall, redirects
    tab.push_back(mk(0,0,0,0,0,X,0,            1,32'h0,  0,32'h0,  0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,X,0,            1,32'h0,  0,32'h0,  0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,X,0,            1,32'h0,  0,32'h0,  0,0,0,0));
    tab.push_back(mk(0,0,0,1,0,X,0,            1,32'h0,  0,32'h0,  0,0,0,0));
    tab.push_back(mk(0,0,0,0,1,32'hA0000000,1,  0,32'h0,  1,32'h4,  0,0,0,0));
    tab.push_back(mk(0,0,1,0,0,X,0,            0,32'h0,  0,32'h4,  1,32'h0,32'hA0000000,0));
    tab.push_back(mk(0,0,1,1,0,X,0,            0,32'h0,  0,32'h4,  1,32'h0,32'hA0000000,0));
    tab.push_back(mk(0,0,0,1,0,X,0,            1,32'h4,  0,32'h4,  1,32'h0,32'hA0000000,0));
    tab.push_back(mk(0,0,0,0,0,X,0,            0,32'h0,  0,32'h4,  0,0,0,0));
    tab.push_back(mk(0,0,0,0,1,32'hA0000001,1,  0,32'h0,  1,32'h8,  0,0,0,0));
    tab.push_back(mk(0,0,0,1,0,X,0,            1,32'h8,  0,32'h8,  1,32'h4,32'hA0000001,0));
    tab.push_back(mk(1,32'h100,0,0,0,X,0,      0,32'h0,  1,32'h100,0,0,0,0));
    tab.push_back(mk(0,0,0,0,1,B,0,            0,32'h0,  0,32'h100,0,0,0,0));
    tab.push_back(mk(0,0,0,1,0,X,0,            1,32'h100,0,32'h100,0,0,0,0));
    tab.push_back(mk(0,0,0,0,1,32'hA0000002,1,  0,32'h0,  1,32'h104,0,0,0,0));
    tab.push_back(mk(0,0,0,1,0,X,0,            1,32'h104,0,32'h104,1,32'h100,32'hA0000002,0));
    tab.push_back(mk(1,32'h200,0,0,1,B,0,      0,32'h0,  1,32'h200,0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,X,0,            1,32'h200,0,32'h200,0,0,0,0));
    tab.push_back(mk(1,32'h300,0,1,0,X,0,      1,32'h200,1,32'h300,0,0,0,0));
    tab.push_back(mk(0,0,0,0,1,B,0,            0,32'h0,  0,32'h300,0,0,0,0));
    tab.push_back(mk(0,0,0,1,0,X,0,            1,32'h300,0,32'h300,0,0,0,0));
    tab.push_back(mk(0,0,0,0,1,32'hA0000003,0,  0,32'h0,  1,32'h304,0,0,0,0));
    tab.push_back(mk(1,32'h400,1,0,0,X,0,      0,32'h0,  1,32'h400,1,32'h300,32'hA0000003,0));
    tab.push_back(mk(0,0,0,0,0,X,0,            1,32'h400,0,32'h400,0,0,0,0));
    tab.push_back(mk(0,0,0,1,0,X,0,            1,32'h400,0,32'h400,0,0,0,0));
    run_tab("g");

    // reset while in WAIT, then stray response after release
    do_reset("r2");
    tab.push_back(mk(0,0,0,0,1,B,0,            1,32'h0,  0,32'h0,  0,0,0,0));
    tab.push_back(mk(0,0,0,1,0,X,0,            1,32'h0,  0,32'h0,  0,0,0,0));
    tab.push_back(mk(0,0,0,0,1,32'hA0000004,1,  0,32'h0,  1,32'h4,  0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,X,0,            1,32'h4,  0,32'h4,  1,32'h0,32'hA0000004,0));
    run_tab("p");

`ifdef JPC_FETCH_MISALIGN_EN
    do_reset("r3");
    tab.push_back(mk(0,0,0,1,0,X,0,            1,32'h0,  0,32'h0,  0,0,0,0));
    tab.push_back(mk(0,0,0,0,1,32'hC0000000,0,  0,32'h0,  1,32'h4,  0,0,0,0));
    tab.push_back(mk(1,32'h102,1,0,0,X,0,      0,32'h0,  0,32'h4,  1,32'h0,32'hC0000000,0));
    tab.push_back(mk(0,0,0,1,0,X,0,            0,32'h0,  0,32'h4,  0,0,0,1));
    tab.push_back(mk(0,0,0,1,0,X,0,            0,32'h0,  0,32'h4,  0,0,0,0));
    tab.push_back(mk(1,32'h40,0,1,0,X,0,       0,32'h0,  1,32'h40, 0,0,0,0));
    tab.push_back(mk(0,0,0,1,0,X,0,            1,32'h40, 0,32'h40, 0,0,0,0));
    tab.push_back(mk(0,0,0,0,1,32'hC0000001,1,  0,32'h0,  1,32'h44, 0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,X,0,            1,32'h44, 0,32'h44, 1,32'h40,32'hC0000001,0));
    run_tab("m");
`endif

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover actual=%0d entries required=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
